// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: retiring-op handshake and load-response bus from the memory stage.
interface writeback_regfile_if #(parameter int BUS_DATA_WIDTH = 64);
  logic in_valid;
  logic in_ready;
  logic in_regWrite;
  logic in_memOrReg;
  logic [4:0] in_destRegister;
  logic [BUS_DATA_WIDTH-1:0] in_aluResult;
  logic [2:0] in_loadType;
  logic [2:0] in_addrOffset;
  logic mem_rsp_valid;
  logic [BUS_DATA_WIDTH-1:0] mem_rsp_data;
  modport master (
    output in_valid, in_regWrite, in_memOrReg, in_destRegister, in_aluResult,
    output in_loadType, in_addrOffset, mem_rsp_valid, mem_rsp_data,
    input in_ready
  );
  modport slave (
    input in_valid, in_regWrite, in_memOrReg, in_destRegister, in_aluResult,
    input in_loadType, in_addrOffset, mem_rsp_valid, mem_rsp_data,
    output in_ready
  );
endinterface

// File: rtl/writeback_regfile.sv
// writeback_regfile: write-back stage owning the 32x64 register file, load narrowing and retire counter.
module writeback_regfile #(parameter int BUS_DATA_WIDTH = 64) (
  input  logic clk,
  input  logic reset_n,
  writeback_regfile_if.slave wb,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  output logic [BUS_DATA_WIDTH-1:0] rs1_data,
  output logic [BUS_DATA_WIDTH-1:0] rs2_data,
  output logic out_stall,
  output logic out_misaligned,
  output logic out_spurious,
  output logic [63:0] out_retired
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t state, nextState;
  logic accept, rspHit, aluCommit, misaligned, wrEn, retire;
  logic isB, isH, isW, isSigned;
  logic pendWrite;
  logic [4:0] pendRd, wrAddr;
  logic [2:0] pendType, pendOff;
  logic [BUS_DATA_WIDTH-1:0] shifted, loadVal, wrData;
  logic [BUS_DATA_WIDTH-1:0] regs [32];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = (state == IDLE) ? ((accept & wb.in_memOrReg) ? WAIT_MEM : IDLE)
                                : (wb.mem_rsp_valid ? IDLE : WAIT_MEM);
  always_comb begin
    wb.in_ready = (state == IDLE);
    out_stall = (state == WAIT_MEM);
    accept = wb.in_valid & (state == IDLE);
  end
  // Load narrowing works off the latched type/offset; 111 falls through to the full-width path.
  always_comb begin
    shifted = wb.mem_rsp_data >> {pendOff, 3'b000};
    isB = (pendType == 3'd1) || (pendType == 3'd4);
    isH = (pendType == 3'd2) || (pendType == 3'd5);
    isW = (pendType == 3'd3) || (pendType == 3'd6);
    isSigned = ~pendType[2];
    loadVal = isB ? {{56{isSigned & shifted[7]}}, shifted[7:0]}
            : isH ? {{48{isSigned & shifted[15]}}, shifted[15:0]}
            : isW ? {{32{isSigned & shifted[31]}}, shifted[31:0]}
            : shifted;
    misaligned = (isH & pendOff[0]) | (isW & |pendOff[1:0]) | (~isB & ~isH & ~isW & |pendOff);
    rspHit = (state == WAIT_MEM) & wb.mem_rsp_valid;
    aluCommit = accept & ~wb.in_memOrReg;
    wrAddr = aluCommit ? wb.in_destRegister : pendRd;
    wrData = aluCommit ? wb.in_aluResult : loadVal;
    wrEn = (aluCommit ? wb.in_regWrite : (rspHit & ~misaligned & pendWrite)) & |wrAddr;
    retire = aluCommit | (rspHit & ~misaligned);
    rs1_data = ~|rs1_addr ? '0 : (wrEn && wrAddr == rs1_addr) ? wrData : regs[rs1_addr];
    rs2_data = ~|rs2_addr ? '0 : (wrEn && wrAddr == rs2_addr) ? wrData : regs[rs2_addr];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      pendRd <= '0;
      pendWrite <= 1'b0;
      pendType <= '0;
      pendOff <= '0;
      out_misaligned <= 1'b0;
      out_spurious <= 1'b0;
      out_retired <= '0;
    end else begin
      if (wrEn) regs[wrAddr] <= wrData;
      if (accept & wb.in_memOrReg) begin
        pendRd <= wb.in_destRegister;
        pendWrite <= wb.in_regWrite;
        pendType <= wb.in_loadType;
        pendOff <= wb.in_addrOffset;
      end
      out_misaligned <= rspHit & misaligned;
      out_spurious <= (state == IDLE) & wb.mem_rsp_valid;
      if (retire) out_retired <= out_retired + 64'd1;
    end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: table-driven ops with a register scoreboard, plus stall/spurious/reset sequences.
module tb_writeback_regfile;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [4:0] rs1_addr = '0, rs2_addr = '0;
  logic [63:0] rs1_data, rs2_data, out_retired;
  logic out_stall, out_misaligned, out_spurious;
  int checks = 0, errors = 0;
  logic [63:0] expRet = '0;
  typedef struct {
    logic mor; logic [4:0] rd; logic [63:0] alu; logic [2:0] lt; logic [2:0] off;
    logic [63:0] rsp; logic mis; logic [63:0] exp;
  } vec_t;
  typedef struct {logic [4:0] rd; logic [63:0] val;} sb_t;
  vec_t vecs [15];
  sb_t sbq [$];
  sb_t s;
  writeback_regfile_if bus ();
  writeback_regfile dut (
    .clk(clk), .reset_n(reset_n), .wb(bus),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_stall(out_stall), .out_misaligned(out_misaligned), .out_spurious(out_spurious),
    .out_retired(out_retired)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    vecs[0]  = '{1'b0, 5'd5,  64'h1234, 3'd0, 3'd0, 64'h0, 1'b0, 64'h1234};
    vecs[1]  = '{1'b1, 5'd6,  64'h0, 3'd1, 3'd3, 64'h0000_0000_80FF_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[2]  = '{1'b1, 5'd7,  64'h0, 3'd4, 3'd3, 64'h0000_0000_80FF_0000, 1'b0, 64'h80};
    vecs[3]  = '{1'b1, 5'd8,  64'h0, 3'd2, 3'd2, 64'h0000_0000_8001_0000, 1'b0, 64'hFFFF_FFFF_FFFF_8001};
    vecs[4]  = '{1'b1, 5'd9,  64'h0, 3'd5, 3'd6, 64'hBEEF_0000_0000_0000, 1'b0, 64'hBEEF};
    vecs[5]  = '{1'b1, 5'd10, 64'h0, 3'd3, 3'd4, 64'h8765_4321_0000_0000, 1'b0, 64'hFFFF_FFFF_8765_4321};
    vecs[6]  = '{1'b1, 5'd11, 64'h0, 3'd6, 3'd0, 64'h0000_0000_F000_0001, 1'b0, 64'hF000_0001};
    vecs[7]  = '{1'b1, 5'd12, 64'h0, 3'd0, 3'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[8]  = '{1'b1, 5'd13, 64'h0, 3'd7, 3'd0, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFEDC_BA98_7654_3210};
    vecs[9]  = '{1'b1, 5'd5,  64'h0, 3'd3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h1234};
    vecs[10] = '{1'b1, 5'd12, 64'h0, 3'd0, 3'd1, 64'h1111_2222_3333_4444, 1'b1, 64'h0123_4567_89AB_CDEF};
    vecs[11] = '{1'b1, 5'd8,  64'h0, 3'd2, 3'd3, 64'h5555_6666_7777_8888, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
    vecs[12] = '{1'b1, 5'd14, 64'h0, 3'd1, 3'd7, 64'h7F00_0000_0000_0000, 1'b0, 64'h7F};
    vecs[13] = '{1'b0, 5'd0,  64'hDEAD, 3'd0, 3'd0, 64'h0, 1'b0, 64'h0};
    vecs[14] = '{1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 3'd0, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    bus.in_valid = 0; bus.in_regWrite = 0; bus.in_memOrReg = 0; bus.in_destRegister = '0;
    bus.in_aluResult = '0; bus.in_loadType = '0; bus.in_addrOffset = '0;
    bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    tick; tick;
    reset_n = 1'b1;
    tick;
    check("rst_ready", bus.in_ready, 1);
    check("rst_stall", out_stall, 0);
    check("rst_retired", out_retired, 0);
    check("rst_mis", out_misaligned, 0);
    check("rst_spur", out_spurious, 0);
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1; bus.in_regWrite = 1; bus.in_memOrReg = vecs[i].mor;
      bus.in_destRegister = vecs[i].rd; bus.in_aluResult = vecs[i].alu;
      bus.in_loadType = vecs[i].lt; bus.in_addrOffset = vecs[i].off;
      sbq.push_back('{vecs[i].rd, vecs[i].exp});
      rs1_addr = vecs[i].rd;
      if (!vecs[i].mor) begin
        #1 check("alu_bypass", rs1_data, vecs[i].exp);
        tick;
        bus.in_valid = 0;
      end else begin
        tick;
        bus.in_valid = 0;
        check("load_wait", out_stall, 1);
        repeat ($urandom_range(0, 2)) tick;
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = vecs[i].rsp;
        #1 check("load_bypass", rs1_data, vecs[i].exp);
        tick;
        bus.mem_rsp_valid = 0;
      end
      if (!vecs[i].mis) expRet++;
      check("misaligned", out_misaligned, vecs[i].mis);
      s = sbq.pop_front();
      rs2_addr = s.rd;
      #1 check("reg", rs2_data, s.val);
      check("retired", out_retired, expRet);
    end
    tick;
    check("mis_clear", out_misaligned, 0);
    // Load accepted with a stray response in the same cycle, then 4 stall cycles with in_valid held.
    bus.in_valid = 1; bus.in_regWrite = 1; bus.in_memOrReg = 1; bus.in_destRegister = 5'd20;
    bus.in_loadType = 3'd0; bus.in_addrOffset = 3'd0;
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 64'h9999;
    tick;
    bus.mem_rsp_valid = 0;
    check("spur_accept", out_spurious, 1);
    bus.in_memOrReg = 0; bus.in_destRegister = 5'd21; bus.in_aluResult = 64'h55;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 64'hCAFE;
      end
      #1 check("stall_ready", bus.in_ready, 0);
      check("stall_out", out_stall, 1);
      tick;
    end
    bus.mem_rsp_valid = 0; bus.in_valid = 0;
    for (int n = 0; n < 16 && !bus.in_ready; n++) tick;
    check("ready_after", bus.in_ready, 1);
    check("spur_wait", out_spurious, 0);
    expRet++;
    check("stall_retired", out_retired, expRet);
    rs2_addr = 5'd20;
    #1 check("stall_load", rs2_data, 64'hCAFE);
    rs2_addr = 5'd21;
    #1 check("stall_ignored", rs2_data, 0);
    tick;
    bus.mem_rsp_valid = 1;
    tick;
    bus.mem_rsp_valid = 0;
    check("spur_idle", out_spurious, 1);
    check("spur_noretire", out_retired, expRet);
    tick;
    check("spur_clear", out_spurious, 0);
    // Reset while a load is pending: the later response must be treated as spurious.
    bus.in_valid = 1; bus.in_memOrReg = 1; bus.in_destRegister = 5'd22; bus.in_loadType = 3'd0;
    tick;
    bus.in_valid = 0;
    check("rw_wait", out_stall, 1);
    #2 reset_n = 1'b0;
    #1 check("rw_ready", bus.in_ready, 1);
    check("rw_retired", out_retired, 0);
    rs2_addr = 5'd5;
    #1 check("rw_clr5", rs2_data, 0);
    rs2_addr = 5'd31;
    #1 check("rw_clr31", rs2_data, 0);
    tick;
    reset_n = 1'b1;
    tick;
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 64'h77;
    tick;
    bus.mem_rsp_valid = 0;
    check("rw_spur", out_spurious, 1);
    check("rw_ready2", bus.in_ready, 1);
    check("rw_noretire", out_retired, 0);
    rs2_addr = 5'd22;
    #1 check("rw_nowrite", rs2_data, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
